pe_multifilter: RTL and testbench

Next-generation Eyeriss processing element. It holds up to `nFiltMax` weight rows in a shared weight scratchpad and one activation row in an activation scratchpad. For each output position it computes a strided 1-D convolution for every loaded filter, and adds the vertically streamed input partial sum to each result. Unlike the single-filter PE, the partial-sum paths in and out are valid/ready handshaked with back-pressure, so cluster control can stall the psum column without losing data.

---
 rtl/pe_multifilter.sv | 212 +++++++++++++++++++++
 tb/tb_pe_multifilter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_multifilter.sv
// Multi-filter Eyeriss PE: strided 1-D convolution of one activation row against
// up to nFiltMax weight rows, with valid/ready handshaked psum input and output.
module pe_multifilter #(
  parameter int dataSize  = 8,
  parameter int wSpadNReg = 16,
  parameter int aSpadNReg = 32,
  parameter int nFiltMax  = 4,
  parameter int accExt    = 4,
  localparam int macResSize = 2*dataSize + accExt
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [dataSize-1:0]   weights_i,
  input  logic                  weights_valid_i,
  input  logic [dataSize-1:0]   acts_i,
  input  logic                  acts_valid_i,
  input  logic [7:0]            cfg_wcount,
  input  logic [7:0]            cfg_acount,
  input  logic [3:0]            cfg_nfilt,
  input  logic [3:0]            cfg_stride,
  input  logic                  ctrl_start,
  input  logic [macResSize-1:0] psum_i,
  input  logic                  psum_valid_i,
  output logic                  psum_ready_o,
  output logic [macResSize-1:0] psum_o,
  output logic                  psum_valid_o,
  input  logic                  psum_ready_i,
  output logic                  busy_o,
  output logic                  flag_done,
  output logic                  err_o
);

  localparam int WAW = (wSpadNReg > 1) ? $clog2(wSpadNReg) : 1;
  localparam int AAW = (aSpadNReg > 1) ? $clog2(aSpadNReg) : 1;
  localparam int WPW = $clog2(wSpadNReg + 1);
  localparam int APW = $clog2(aSpadNReg + 1);
  localparam int PW  = 2*dataSize;

  localparam logic [WPW-1:0] W_FULL   = WPW'(wSpadNReg);
  localparam logic [APW-1:0] A_FULL   = APW'(aSpadNReg);
  localparam logic [31:0]    W_DEPTH  = 32'(wSpadNReg);
  localparam logic [31:0]    A_DEPTH  = 32'(aSpadNReg);
  localparam logic [31:0]    NF_MAX   = 32'(nFiltMax);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

  state_t state_q, state_d;

  logic [dataSize-1:0] wspad [wSpadNReg];
  logic [dataSize-1:0] aspad [aSpadNReg];

  logic [WPW-1:0] wptr_q;
  logic [APW-1:0] aptr_q;

  logic [7:0] wcount_q, acount_q;
  logic [3:0] nfilt_q, stride_q;

  logic [7:0]     tap_q;
  logic [3:0]     filt_q;
  logic [WAW-1:0] wbase_q;
  logic [AAW-1:0] abase_q;

  logic [macResSize-1:0] acc_q, pend_q, out_q;
  logic                  pend_full_q, out_valid_q, err_q;

  logic cfg_bad, start_ok, start_err;
  logic w_wr, a_wr;
  logic [WAW-1:0] w_addr;
  logic [AAW-1:0] a_addr;
  logic [PW-1:0]  prod;
  logic [macResSize-1:0] mac_sum;
  logic last_tap, last_filt, last_pos;
  logic free, mac_en, result_done, last_result;

  assign cfg_bad = (cfg_wcount == 8'd0) || (cfg_stride == 4'd0) || (cfg_nfilt == 4'd0)
                || (32'(cfg_nfilt) > NF_MAX)
                || (cfg_wcount > cfg_acount)
                || (32'(cfg_acount) > A_DEPTH)
                || (32'(cfg_nfilt) * 32'(cfg_wcount) > W_DEPTH);

  assign start_ok  = (state_q == IDLE) && ctrl_start && !cfg_bad;
  assign start_err = (state_q == IDLE) && ctrl_start && cfg_bad;

  assign w_wr = (state_q == IDLE) && weights_valid_i && (wptr_q < W_FULL);
  assign a_wr = (state_q == IDLE) && acts_valid_i && (aptr_q < A_FULL);

  // Weights are filter-major, so the weight address is the filter base plus tap.
  assign w_addr  = wbase_q + WAW'(tap_q);
  assign a_addr  = abase_q + AAW'(tap_q);
  assign prod    = PW'(wspad[w_addr]) * PW'(aspad[a_addr]);
  assign mac_sum = acc_q + macResSize'(prod);

  assign last_tap  = (tap_q == wcount_q - 8'd1);
  assign last_filt = (filt_q == nfilt_q - 4'd1);
  // Last position when the next window would run past the activation row.
  assign last_pos  = (16'(abase_q) + 16'(stride_q) + 16'(wcount_q)) > 16'(acount_q);

  assign psum_ready_o = pend_full_q && (!out_valid_q || psum_ready_i);
  assign free         = psum_ready_o && psum_valid_i;

  assign mac_en      = (state_q == COMPUTE) && (!last_tap || !pend_full_q || free);
  assign result_done = mac_en && last_tap;
  assign last_result = result_done && last_filt && last_pos;

  assign flag_done    = (state_q == DRAIN) && !pend_full_q && out_valid_q && psum_ready_i;
  assign busy_o       = (state_q != IDLE);
  assign psum_o       = out_q;
  assign psum_valid_o = out_valid_q;
  assign err_o        = err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)    state_d = COMPUTE;
      COMPUTE: if (last_result) state_d = DRAIN;
      DRAIN:   if (flag_done)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) wspad[wptr_q[WAW-1:0]] <= weights_i;
    if (a_wr) aspad[aptr_q[AAW-1:0]] <= acts_i;
  end

  // A load in the start cycle still lands in the scratchpad; the clear wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q <= '0;
      aptr_q <= '0;
    end else if (start_ok) begin
      wptr_q <= '0;
      aptr_q <= '0;
    end else begin
      if (w_wr) wptr_q <= wptr_q + WPW'(1);
      if (a_wr) aptr_q <= aptr_q + APW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcount_q <= '0;
      acount_q <= '0;
      nfilt_q  <= '0;
      stride_q <= '0;
    end else if (start_ok) begin
      wcount_q <= cfg_wcount;
      acount_q <= cfg_acount;
      nfilt_q  <= cfg_nfilt;
      stride_q <= cfg_stride;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tap_q   <= '0;
      filt_q  <= '0;
      wbase_q <= '0;
      abase_q <= '0;
      acc_q   <= '0;
      pend_q  <= '0;
    end else if (start_ok) begin
      tap_q   <= '0;
      filt_q  <= '0;
      wbase_q <= '0;
      abase_q <= '0;
      acc_q   <= '0;
    end else if (mac_en) begin
      if (!last_tap) begin
        acc_q <= mac_sum;
        tap_q <= tap_q + 8'd1;
      end else begin
        pend_q <= mac_sum;
        acc_q  <= '0;
        tap_q  <= '0;
        if (last_filt) begin
          filt_q  <= '0;
          wbase_q <= '0;
          abase_q <= abase_q + AAW'(stride_q);
        end else begin
          filt_q  <= filt_q + 4'd1;
          wbase_q <= wbase_q + WAW'(wcount_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_full_q <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= start_err;
      if (result_done)  pend_full_q <= 1'b1;
      else if (free)    pend_full_q <= 1'b0;
      if (free) begin
        out_q       <= pend_q + psum_i;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && psum_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_multifilter.sv
// Directed bench for pe_multifilter: loads scratchpads, runs jobs under several
// psum handshake patterns and compares against hand-computed results.
module tb_pe_multifilter;

  localparam int MRS = 20;

  logic           clk = 1'b0;
  logic           nrst;
  logic [7:0]     weights_i, acts_i;
  logic           weights_valid_i, acts_valid_i;
  logic [7:0]     cfg_wcount, cfg_acount;
  logic [3:0]     cfg_nfilt, cfg_stride;
  logic           ctrl_start;
  logic [MRS-1:0] psum_i;
  logic           psum_valid_i;
  logic           psum_ready_o;
  logic [MRS-1:0] psum_o;
  logic           psum_valid_o;
  logic           psum_ready_i;
  logic           busy_o, flag_done, err_o;

  int checks = 0;
  int errors = 0;

  logic [MRS-1:0] got [$];
  int done_cnt, stable_viol, ready_viol, gap_viol, first_valid_cyc, timed_out;

  logic [MRS-1:0] exp_mf [8] = '{20'd3, 20'd2, 20'd7, 20'd6, 20'd11, 20'd10, 20'd15, 20'd14};

  pe_multifilter #(
    .dataSize(8),
    .wSpadNReg(16),
    .aSpadNReg(32),
    .nFiltMax(4),
    .accExt(4)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .weights_i(weights_i),
    .weights_valid_i(weights_valid_i),
    .acts_i(acts_i),
    .acts_valid_i(acts_valid_i),
    .cfg_wcount(cfg_wcount),
    .cfg_acount(cfg_acount),
    .cfg_nfilt(cfg_nfilt),
    .cfg_stride(cfg_stride),
    .ctrl_start(ctrl_start),
    .psum_i(psum_i),
    .psum_valid_i(psum_valid_i),
    .psum_ready_o(psum_ready_o),
    .psum_o(psum_o),
    .psum_valid_o(psum_valid_o),
    .psum_ready_i(psum_ready_i),
    .busy_o(busy_o),
    .flag_done(flag_done),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic write_w(input logic [7:0] v);
    weights_i = v;
    weights_valid_i = 1'b1;
    @(posedge clk); #1;
    weights_valid_i = 1'b0;
  endtask

  task automatic write_a(input logic [7:0] v);
    acts_i = v;
    acts_valid_i = 1'b1;
    @(posedge clk); #1;
    acts_valid_i = 1'b0;
  endtask

  task automatic load_baseline();
    for (int i = 1; i <= 3; i++) write_w(8'(i));
    for (int i = 1; i <= 16; i++) write_a(8'(i));
  endtask

  task automatic start_job(input logic [7:0] wc, input logic [7:0] ac,
                           input logic [3:0] nf, input logic [3:0] st);
    cfg_wcount = wc;
    cfg_acount = ac;
    cfg_nfilt  = nf;
    cfg_stride = st;
    ctrl_start = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
  endtask

  // Drives the psum handshakes for one job and records what the DUT produced.
  task automatic run_job(input logic [MRS-1:0] psum_val, input int bp, input int gap);
    logic prev_stall, prev_vin, prev_ovalid, prev_acc;
    logic [MRS-1:0] prev_val;
    got.delete();
    done_cnt = 0; stable_viol = 0; ready_viol = 0; gap_viol = 0;
    first_valid_cyc = -1; timed_out = 1;
    prev_stall = 1'b0; prev_vin = 1'b1; prev_ovalid = 1'b0; prev_acc = 1'b0; prev_val = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      psum_ready_i = (bp != 0) ? ((cyc >= 20) && (cyc % 2 == 0)) : 1'b1;
      psum_valid_i = (gap != 0) ? (cyc % 2 == 0) : 1'b1;
      psum_i       = psum_valid_i ? psum_val : 20'hABCDE;
      #1;
      if (psum_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (!psum_valid_o || psum_o !== prev_val)) stable_viol++;
      if (psum_ready_o && psum_valid_o && !psum_ready_i) ready_viol++;
      if (psum_valid_o && (!prev_ovalid || prev_acc) && !prev_vin) gap_viol++;
      if (psum_valid_o && psum_ready_i) got.push_back(psum_o);
      if (flag_done) done_cnt++;
      prev_stall  = psum_valid_o && !psum_ready_i;
      prev_acc    = psum_valid_o && psum_ready_i;
      prev_val    = psum_o;
      prev_vin    = psum_valid_i;
      prev_ovalid = psum_valid_o;
      if (done_cnt > 0 && !busy_o) begin
        timed_out = 0;
        break;
      end
      @(posedge clk); #1;
    end
    psum_valid_i = 1'b0;
    psum_ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (psum_o !== '0)       begin errors++; $display("FAIL reset_psum_o: got %0d expected 0", psum_o); end
    checks++; if (psum_valid_o !== 0)  begin errors++; $display("FAIL reset_psum_valid_o: got %b expected 0", psum_valid_o); end
    checks++; if (psum_ready_o !== 0)  begin errors++; $display("FAIL reset_psum_ready_o: got %b expected 0", psum_ready_o); end
    checks++; if (busy_o !== 0)        begin errors++; $display("FAIL reset_busy_o: got %b expected 0", busy_o); end
    checks++; if (flag_done !== 0)     begin errors++; $display("FAIL reset_flag_done: got %b expected 0", flag_done); end
    checks++; if (err_o !== 0)         begin errors++; $display("FAIL reset_err_o: got %b expected 0", err_o); end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_baseline();
    logic [MRS-1:0] act, exp;
    load_baseline();
    start_job(8'd3, 8'd16, 4'd1, 4'd1);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL base_busy: got %b expected 1", busy_o); end
    run_job(20'd1, 0, 0);
    checks++; if (timed_out !== 0)  begin errors++; $display("FAIL base_timeout: got %0d expected 0", timed_out); end
    checks++; if (got.size() != 14) begin errors++; $display("FAIL base_count: got %0d expected 14", got.size()); end
    checks++; if (first_valid_cyc != 4) begin errors++; $display("FAIL base_latency: got %0d expected 4", first_valid_cyc); end
    for (int p = 0; p < 14; p++) begin
      exp = 20'(6*p + 15);
      act = (p < got.size()) ? got[p] : 'x;
      checks++;
      if (act !== exp) begin errors++; $display("FAIL base_val[%0d]: got %0d expected %0d", p, act, exp); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL base_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_multifilter();
    logic [MRS-1:0] act;
    write_w(8'd1); write_w(8'd1); write_w(8'd2); write_w(8'd0);
    for (int i = 1; i <= 8; i++) write_a(8'(i));
    start_job(8'd2, 8'd8, 4'd2, 4'd2);
    // Configuration changes after start must be ignored.
    cfg_wcount = 8'd7;
    cfg_stride = 4'd1;
    run_job(20'd0, 0, 0);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL mf_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      act = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (act !== exp_mf[i]) begin errors++; $display("FAIL mf_val[%0d]: got %0d expected %0d", i, act, exp_mf[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL mf_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [MRS-1:0] act, exp;
    load_baseline();
    start_job(8'd3, 8'd16, 4'd1, 4'd1);
    run_job(20'd1, 1, 0);
    checks++; if (timed_out !== 0)  begin errors++; $display("FAIL bp_timeout: got %0d expected 0", timed_out); end
    checks++; if (got.size() != 14) begin errors++; $display("FAIL bp_count: got %0d expected 14", got.size()); end
    for (int p = 0; p < 14; p++) begin
      exp = 20'(6*p + 15);
      act = (p < got.size()) ? got[p] : 'x;
      checks++;
      if (act !== exp) begin errors++; $display("FAIL bp_val[%0d]: got %0d expected %0d", p, act, exp); end
    end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_viol); end
    checks++; if (ready_viol != 0)  begin errors++; $display("FAIL bp_ready_o: got %0d cycles high while full expected 0", ready_viol); end
    checks++; if (done_cnt != 1)    begin errors++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_upstream_gaps();
    logic [MRS-1:0] act, exp;
    load_baseline();
    start_job(8'd3, 8'd16, 4'd1, 4'd1);
    run_job(20'd1, 0, 1);
    checks++; if (got.size() != 14) begin errors++; $display("FAIL gap_count: got %0d expected 14", got.size()); end
    for (int p = 0; p < 14; p++) begin
      exp = 20'(6*p + 15);
      act = (p < got.size()) ? got[p] : 'x;
      checks++;
      if (act !== exp) begin errors++; $display("FAIL gap_val[%0d]: got %0d expected %0d", p, act, exp); end
    end
    checks++; if (gap_viol != 0) begin errors++; $display("FAIL gap_consume: got %0d loads without valid expected 0", gap_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL gap_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wraparound();
    logic [MRS-1:0] act;
    for (int i = 0; i < 16; i++) write_w(8'd255);
    for (int i = 0; i < 16; i++) write_a(8'd255);
    start_job(8'd16, 8'd16, 4'd1, 4'd1);
    run_job(20'hFFFFF, 0, 0);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", got.size()); end
    act = (got.size() > 0) ? got[0] : 'x;
    checks++; if (act !== 20'd1040399) begin errors++; $display("FAIL wrap_val: got %0d expected 1040399", act); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reject_and_reset();
    logic [7:0] rej_wc [5] = '{8'd5, 8'd3, 8'd6, 8'd3, 8'd3};
    logic [7:0] rej_ac [5] = '{8'd4, 8'd16, 8'd16, 8'd16, 8'd40};
    logic [3:0] rej_nf [5] = '{4'd1, 4'd5, 4'd3, 4'd1, 4'd1};
    logic [3:0] rej_st [5] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
    int late_done;
    for (int i = 0; i < 5; i++) begin
      start_job(rej_wc[i], rej_ac[i], rej_nf[i], rej_st[i]);
      checks++; if (err_o !== 1'b1)  begin errors++; $display("FAIL rej_err[%0d]: got %b expected 1", i, err_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rej_busy[%0d]: got %b expected 0", i, busy_o); end
      @(posedge clk); #1;
      checks++; if (err_o !== 1'b0)  begin errors++; $display("FAIL rej_err_clear[%0d]: got %b expected 0", i, err_o); end
    end

    load_baseline();
    start_job(8'd3, 8'd16, 4'd1, 4'd1);
    psum_valid_i = 1'b1;
    psum_i       = 20'd1;
    psum_ready_i = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checks++; if (psum_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", psum_valid_o); end
    nrst = 1'b0;
    #1;
    checks++; if (psum_o !== '0)       begin errors++; $display("FAIL rst_psum_o: got %0d expected 0", psum_o); end
    checks++; if (psum_valid_o !== 0)  begin errors++; $display("FAIL rst_psum_valid_o: got %b expected 0", psum_valid_o); end
    checks++; if (psum_ready_o !== 0)  begin errors++; $display("FAIL rst_psum_ready_o: got %b expected 0", psum_ready_o); end
    checks++; if (busy_o !== 0)        begin errors++; $display("FAIL rst_busy_o: got %b expected 0", busy_o); end
    checks++; if (flag_done !== 0)     begin errors++; $display("FAIL rst_flag_done: got %b expected 0", flag_done); end
    checks++; if (err_o !== 0)         begin errors++; $display("FAIL rst_err_o: got %b expected 0", err_o); end
    psum_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    late_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (flag_done || busy_o) late_done++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles expected 0", late_done); end
    psum_valid_i = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    weights_i = '0; weights_valid_i = 1'b0;
    acts_i = '0; acts_valid_i = 1'b0;
    cfg_wcount = '0; cfg_acount = '0; cfg_nfilt = '0; cfg_stride = '0;
    ctrl_start = 1'b0;
    psum_i = '0; psum_valid_i = 1'b0; psum_ready_i = 1'b1;
    #1;
    test_reset();
    test_baseline();
    test_multifilter();
    test_backpressure();
    test_upstream_gaps();
    test_wraparound();
    test_reject_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
